// File: rtl/fp_addsub_seq.sv
// Sequential floating-point adder/subtractor: one operation in flight, RNE rounding,
// subnormals flushed to zero, valid/ready handshake on both sides.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  // datapath word: carry | hidden | mantissa | guard | round | sticky
  localparam int DW = MAN_W + 5;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W:0]   EXP_MAX  = {1'b0, EXP_ONES};
  localparam logic [EXP_W:0]   EXP_ONE  = (EXP_W+1)'(1);
  localparam logic [DW-1:0]    DW_ONE   = DW'(1);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state, state_nxt;

  logic [W-1:0]   cap_a, cap_b;
  logic           cap_op;
  logic           sign_r, sub_r;
  logic [EXP_W:0] exp_r;
  logic [DW-1:0]  man, sml;
  logic [W-1:0]   res_q;
  logic [3:0]     flg_q;

  // ---------------- align / classify ----------------
  logic             sa, sb, za, zb, na, nb, ia, ib, a_ge, special;
  logic [EXP_W-1:0] ea, eb, e_big, e_sml, diff;
  logic [MAN_W-1:0] ma, mb;
  logic [DW-1:0]    big_ext, sml_ext, sml_sh, lost_mask;
  logic [W-1:0]     sp_res;
  logic [3:0]       sp_flags;

  assign sa = cap_a[W-1];
  assign sb = cap_b[W-1] ^ cap_op;
  assign ea = cap_a[W-2 -: EXP_W];
  assign eb = cap_b[W-2 -: EXP_W];
  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign na = (ea == EXP_ONES) && (cap_a[MAN_W-1:0] != '0);
  assign nb = (eb == EXP_ONES) && (cap_b[MAN_W-1:0] != '0);
  assign ia = (ea == EXP_ONES) && (cap_a[MAN_W-1:0] == '0);
  assign ib = (eb == EXP_ONES) && (cap_b[MAN_W-1:0] == '0);
  // subnormals carry no significand: they behave as signed zeros
  assign ma = za ? '0 : cap_a[MAN_W-1:0];
  assign mb = zb ? '0 : cap_b[MAN_W-1:0];

  assign a_ge    = {ea, ma} >= {eb, mb};
  assign e_big   = a_ge ? ea : eb;
  assign e_sml   = a_ge ? eb : ea;
  assign big_ext = a_ge ? {1'b0, ~za, ma, 3'b000} : {1'b0, ~zb, mb, 3'b000};
  assign sml_ext = a_ge ? {1'b0, ~zb, mb, 3'b000} : {1'b0, ~za, ma, 3'b000};
  assign diff    = e_big - e_sml;
  assign special = na | nb | ia | ib | (za & zb);

  always_comb begin
    lost_mask = (DW_ONE << diff) - DW_ONE;
    if (32'(diff) >= 32'(MAN_W + 3))
      sml_sh = {{(DW-1){1'b0}}, |sml_ext};
    else
      sml_sh = (sml_ext >> diff) | {{(DW-1){1'b0}}, |(sml_ext & lost_mask)};
  end

  always_comb begin
    sp_res   = '0;
    sp_flags = '0;
    if (na | nb | (ia & ib & (sa != sb))) begin
      sp_res   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      sp_flags = 4'b1000;
    end else if (ia) begin
      sp_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (ib) begin
      sp_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      sp_res = {sa & sb, {(W-1){1'b0}}};
    end
  end

  // ---------------- add / normalise ----------------
  logic [DW-1:0] sum;
  logic          carry, hid, nz, norm_shl;

  assign sum      = sub_r ? man - sml : man + sml;
  assign carry    = man[DW-1];
  assign hid      = man[DW-2];
  assign nz       = |man;
  // an exact zero stops normalising at once so cancellation stays fast
  assign norm_shl = !carry && nz && !hid && (exp_r > EXP_ONE);

  // ---------------- round / pack ----------------
  logic [MAN_W:0]   m_n;
  logic [MAN_W+1:0] m_r;
  logic             g_b, r_b, s_b, rup;
  logic [EXP_W:0]   exp_fin;
  logic [MAN_W-1:0] man_fin;
  logic [W-1:0]     rnd_res;
  logic [3:0]       rnd_flags;

  assign m_n     = man[DW-2:3];
  assign g_b     = man[2];
  assign r_b     = man[1];
  assign s_b     = man[0];
  assign rup     = g_b & (r_b | s_b | m_n[0]);
  assign m_r     = {1'b0, m_n} + {{(MAN_W+1){1'b0}}, rup};
  assign exp_fin = m_r[MAN_W+1] ? exp_r + EXP_ONE : exp_r;
  assign man_fin = m_r[MAN_W+1] ? m_r[MAN_W:1] : m_r[MAN_W-1:0];

  always_comb begin
    rnd_res   = '0;
    rnd_flags = '0;
    if (!nz) begin
      rnd_res   = '0;
      rnd_flags = '0;
    end else if (!hid) begin
      // below the normal range: the whole nonzero value is lost
      rnd_res   = {sign_r, {(W-1){1'b0}}};
      rnd_flags = 4'b0011;
    end else if (exp_fin >= EXP_MAX) begin
      rnd_res   = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
      rnd_flags = 4'b0101;
    end else begin
      rnd_res   = {sign_r, exp_fin[EXP_W-1:0], man_fin};
      rnd_flags = {3'b000, g_b | r_b | s_b};
    end
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ALIGN;
      ALIGN:   state_nxt = special ? DONE : ADD;
      ADD:     state_nxt = NORM;
      NORM:    if (!norm_shl) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_a  <= '0;
      cap_b  <= '0;
      cap_op <= 1'b0;
      sign_r <= 1'b0;
      sub_r  <= 1'b0;
      exp_r  <= '0;
      man    <= '0;
      sml    <= '0;
      res_q  <= '0;
      flg_q  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          cap_a  <= a;
          cap_b  <= b;
          cap_op <= op;
        end
        ALIGN: if (special) begin
          res_q <= sp_res;
          flg_q <= sp_flags;
        end else begin
          sign_r <= a_ge ? sa : sb;
          sub_r  <= sa ^ sb;
          exp_r  <= {1'b0, e_big};
          man    <= big_ext;
          sml    <= sml_sh;
        end
        ADD: man <= sum;
        NORM: if (carry) begin
          man   <= {1'b0, man[DW-1:2], man[1] | man[0]};
          exp_r <= exp_r + EXP_ONE;
        end else if (norm_shl) begin
          man   <= man << 1;
          exp_r <= exp_r - EXP_ONE;
        end
        ROUND: begin
          res_q <= rnd_res;
          flg_q <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_q;
  assign flags     = flg_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: directed spot values, handshake/reset behaviour, and a random
// sweep at 8/23 and 5/10 against an exact wide-integer RNE/flush-to-zero model.
module tb_fp_addsub_seq;

  typedef logic [319:0] wide_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        iv[2], opx[2], ordy[2];
  logic [31:0] av[2], bv[2];
  logic        ir[2], ov[2];
  logic [31:0] res[2];
  logic [3:0]  fl[2];

  logic        ir8, ov8, ir5, ov5;
  logic [31:0] r8;
  logic [15:0] r5;
  logic [3:0]  f8, f5;

  int n_chk = 0;
  int n_fail = 0;

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) u_f32 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir8), .a(av[0]), .b(bv[0]),
    .op(opx[0]), .out_valid(ov8), .out_ready(ordy[0]), .result(r8), .flags(f8));

  fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) u_f16 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir5), .a(av[1][15:0]),
    .b(bv[1][15:0]), .op(opx[1]), .out_valid(ov5), .out_ready(ordy[1]), .result(r5), .flags(f5));

  assign ir[0] = ir8;  assign ov[0] = ov8;  assign res[0] = r8;           assign fl[0] = f8;
  assign ir[1] = ir5;  assign ov[1] = ov5;  assign res[1] = {16'h0, r5};  assign fl[1] = f5;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int d, input logic [31:0] a, input logic [31:0] b, input logic o);
    int n;
    n = 0;
    while (!ir[d] && n < 200) begin tick(); n++; end
    chk("in_ready_wait", 32'(ir[d]), 32'd1);
    av[d] = a; bv[d] = b; opx[d] = o; iv[d] = 1'b1;
    tick();
    iv[d] = 1'b0;
    av[d] = $urandom; bv[d] = $urandom; opx[d] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = 1;
    while (!ov[d] && lat < 100) begin tick(); lat++; end
    chk("out_valid_timeout", 32'(ov[d]), 32'd1);
  endtask

  task automatic consume(input int d);
    ordy[d] = 1'b1;
    tick();
    ordy[d] = 1'b0;
  endtask

  task automatic run(input int d, input logic [31:0] a, input logic [31:0] b, input logic o,
                     output logic [31:0] r, output logic [3:0] f, output int lat);
    start(d, a, b, o);
    wait_done(d, lat);
    r = res[d];
    f = fl[d];
    consume(d);
  endtask

  task automatic dtest(input int d, input logic [31:0] a, input logic [31:0] b, input logic o,
                       input logic [31:0] er, input logic [3:0] ef, input int elat);
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    run(d, a, b, o, r, f, lat);
    chk($sformatf("dir_res %h%s%h", a, o ? "-" : "+", b), r, er);
    chk($sformatf("dir_flags %h%s%h", a, o ? "-" : "+", b), 32'(f), 32'(ef));
    chk($sformatf("dir_lat %h%s%h", a, o ? "-" : "+", b), 32'(lat), 32'(elat));
  endtask

  function automatic logic [31:0] pack(int ew, int mw, logic s, int e, logic [31:0] m);
    return (32'(s) << (ew + mw)) | (32'(e) << mw) | m;
  endfunction

  // Exact value of each normal operand as an integer in units of the smallest normal ulp;
  // the exact sum is then rounded to nearest-even with flush-to-zero below the normal range.
  function automatic void ref_op(input int ew, input int mw, input logic [31:0] a,
                                 input logic [31:0] b, input logic op,
                                 output logic [31:0] r, output logic [3:0] f);
    wide_t       va, vb, mag, rem, half, q;
    int          emax, ea, eb, p, sh, er;
    logic [31:0] ma, mb, mmask;
    logic        sa, sb, s, nan_a, nan_b, inf_a, inf_b;
    emax  = (1 << ew) - 1;
    mmask = (32'd1 << mw) - 1;
    sa = a[ew+mw];
    sb = b[ew+mw] ^ op;
    ea = int'((a >> mw) & 32'(emax));
    eb = int'((b >> mw) & 32'(emax));
    ma = a & mmask;
    mb = b & mmask;
    nan_a = (ea == emax) && (ma != 0);  inf_a = (ea == emax) && (ma == 0);
    nan_b = (eb == emax) && (mb != 0);  inf_b = (eb == emax) && (mb == 0);
    r = '0; f = '0;
    if (nan_a || nan_b || (inf_a && inf_b && sa != sb)) begin
      r = pack(ew, mw, 1'b0, emax, 32'd1 << (mw - 1)); f = 4'b1000;
    end else if (inf_a) begin
      r = pack(ew, mw, sa, emax, 0);
    end else if (inf_b) begin
      r = pack(ew, mw, sb, emax, 0);
    end else if (ea == 0 && eb == 0) begin
      r = pack(ew, mw, sa & sb, 0, 0);
    end else begin
      va = (ea == 0) ? '0 : ((wide_t'(ma) | (wide_t'(1) << mw)) << (ea - 1));
      vb = (eb == 0) ? '0 : ((wide_t'(mb) | (wide_t'(1) << mw)) << (eb - 1));
      if (sa == sb)      begin mag = va + vb; s = sa; end
      else if (va >= vb) begin mag = va - vb; s = sa; end
      else               begin mag = vb - va; s = sb; end
      if (mag == 0) begin
        r = '0;
      end else begin
        p = 0;
        for (int i = 319; i >= 0; i--) if (mag[i]) begin p = i; break; end
        if (p < mw) begin
          r = pack(ew, mw, s, 0, 0); f = 4'b0011;
        end else begin
          sh  = p - mw;
          q   = mag >> sh;
          rem = mag & ((wide_t'(1) << sh) - 1);
          er  = sh + 1;
          if (sh > 0) begin
            half = wide_t'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
          end
          if (q == (wide_t'(1) << (mw + 1))) begin q = q >> 1; er++; end
          if (er >= emax) begin
            r = pack(ew, mw, s, emax, 0); f = 4'b0101;
          end else begin
            r = pack(ew, mw, s, er, 32'(q) & mmask); f = {3'b000, rem != 0};
          end
        end
      end
    end
  endfunction

  function automatic logic [31:0] rnd_word(int ew, int mw, logic [31:0] refw, bit near);
    int          emax, e, er, k;
    logic [31:0] m, mmask;
    emax  = (1 << ew) - 1;
    mmask = (32'd1 << mw) - 1;
    m  = $urandom & mmask;
    e  = int'($urandom_range(1, emax - 1));
    k  = int'($urandom_range(0, 19));
    er = int'((refw >> mw) & 32'(emax));
    if (near) begin
      e = er + int'($urandom_range(0, 6)) - 3;
      if (e < 1) e = 1;
      if (e > emax - 1) e = emax - 1;
      if (k < 4) m = refw & mmask;
      if (k < 2) m = (m ^ 32'($urandom_range(0, 3))) & mmask;
    end
    if (k == 16) m = mmask;
    if (k == 17) m = '0;
    if (k == 18) e = 0;
    if (k == 19) begin e = emax; if ($urandom_range(0, 1) == 1) m = '0; end
    return pack(ew, mw, 1'($urandom_range(0, 1)), e, m);
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, er, hold_r, a, b;
    logic [3:0]  f, ef, hold_f;
    logic        o;
    int          lat, ew, mw;

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; opx[d] = 1'b0; ordy[d] = 1'b0; av[d] = '0; bv[d] = '0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("reset_in_ready", 32'(ir[d]), 32'd1);
      chk("reset_out_valid", 32'(ov[d]), 32'd0);
      chk("reset_result", res[d], 32'd0);
      chk("reset_flags", 32'(fl[d]), 32'd0);
    end
    reset = 1'b0;

    // first accept lands on the first edge after reset release
    dtest(0, 32'h42000000, 32'h42000000, 1'b0, 32'h42800000, 4'h0, 5);
    dtest(0, 32'h42000000, 32'h40A00000, 1'b0, 32'h42140000, 4'h0, 5);
    dtest(0, 32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 4'h0, 7);
    dtest(0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0, 5);
    dtest(0, 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8, 2);
    dtest(0, 32'h00000001, 32'h80000000, 1'b0, 32'h00000000, 4'h0, 2);
    dtest(0, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'h0, 2);
    dtest(0, 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 4'h1, 5);
    dtest(0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1, 5);
    dtest(0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1, 5);
    dtest(0, 32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'h3, 5);
    dtest(0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8, 2);
    dtest(0, 32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'h0, 2);
    dtest(0, 32'hBF800000, 32'h3F800000, 1'b1, 32'hC0000000, 4'h0, 5);
    dtest(0, 32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'h0, 5);
    dtest(0, 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'h0, 28);
    dtest(0, 32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'h0, 29);
    dtest(1, 32'h3C00, 32'h3C00, 1'b0, 32'h4000, 4'h0, 5);
    dtest(1, 32'h3C00, 32'h3A00, 1'b1, 32'h3400, 4'h0, 7);
    dtest(1, 32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 4'h5, 5);

    // consumer stalls: result held, no new accept possible
    start(0, 32'h42000000, 32'h40A00000, 1'b0);
    wait_done(0, lat);
    hold_r = res[0];
    hold_f = fl[0];
    chk("hold_first", hold_r, 32'h42140000);
    repeat (10) begin
      tick();
      chk("hold_result", res[0], hold_r);
      chk("hold_flags", 32'(fl[0]), 32'(hold_f));
      chk("hold_out_valid", 32'(ov[0]), 32'd1);
      chk("hold_in_ready", 32'(ir[0]), 32'd0);
    end
    consume(0);
    chk("ready_after_consume", 32'(ir[0]), 32'd1);
    chk("valid_after_consume", 32'(ov[0]), 32'd0);

    // reset while the left-shift normalisation is in progress
    dtest(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5, 5);
    start(0, 32'h3F800000, 32'h3F400000, 1'b1);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_in_ready", 32'(ir[0]), 32'd1);
    chk("mid_reset_out_valid", 32'(ov[0]), 32'd0);
    chk("mid_reset_result", res[0], 32'd0);
    chk("mid_reset_flags", 32'(fl[0]), 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    repeat (4) begin
      tick();
      chk("post_reset_no_out", 32'(ov[0]), 32'd0);
    end
    dtest(0, 32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 4'h0, 7);

    for (int d = 0; d < 2; d++) begin
      ew = (d == 0) ? 8 : 5;
      mw = (d == 0) ? 23 : 10;
      b  = $urandom;
      repeat (300) begin
        a = rnd_word(ew, mw, b, 1'b0);
        b = rnd_word(ew, mw, a, $urandom_range(0, 3) != 0);
        o = 1'($urandom_range(0, 1));
        ref_op(ew, mw, a, b, o, er, ef);
        run(d, a, b, o, r, f, lat);
        chk($sformatf("rnd%0d_res %h%s%h", ew, a, o ? "-" : "+", b), r, er);
        chk($sformatf("rnd%0d_flags %h%s%h", ew, a, o ? "-" : "+", b), 32'(f), 32'(ef));
        chk($sformatf("rnd%0d_lat_bound lat=%0d", ew, lat), 32'(lat >= 2 && lat <= 6 + mw), 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_addsub_seq.md
FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, meaning stored mantissa width without the hidden bit; word width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have the following ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A (sign|exp|mant).
- b  input  W  operand B.
- op  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  W  packed sum/difference.
- flags  output  4  {invalid, overflow, underflow, inexact}, qualified by out_valid.

Function
REQ-004 Operands SHALL be accepted on a rising edge where in_valid && in_ready; a, b and op SHALL be captured at that edge only.
REQ-005 in_ready SHALL be 1 only in state IDLE; there is one operation in flight at a time.
REQ-006 The FSM SHALL have states IDLE, ALIGN, ADD, NORM, ROUND and DONE.
- IDLE -> ALIGN on accept.
- ALIGN -> ADD, or ALIGN -> DONE for special or zero cases.
- ADD -> NORM.
- NORM -> NORM while not normalised.
- NORM -> ROUND.
- ROUND -> DONE.
- DONE -> IDLE on out_ready.
REQ-007 In ALIGN, the block SHALL:
- flip B's sign when op=1;
- order operands so the larger magnitude (exponent, then mantissa) is the big operand;
- insert the hidden bit;
- right-shift the small mantissa by the exponent difference, keeping guard, round and sticky bits.
REQ-008 A shift of MAN_W+3 or more SHALL zero the shifted mantissa and set sticky if the small mantissa was nonzero.
REQ-009 In ADD, the mantissas SHALL be added when signs are equal and small subtracted from big otherwise; the datapath SHALL be MAN_W+5 bits wide (carry, hidden bit, mantissa, G, R, S).
REQ-010 In NORM, the block SHALL:
- on carry-out: shift right 1 with the shifted-out bit ORed into sticky, increment the exponent, and leave NORM;
- else, while the hidden bit is 0 and exponent > 1: shift left 1 and decrement the exponent, one bit per cycle;
- otherwise leave NORM.
REQ-011 ROUND SHALL round to nearest, ties to even, using G/R/S; a rounding carry SHALL renormalise (shift right 1, exponent +1) in the same cycle.
REQ-012 inexact SHALL be set whenever any of G/R/S is nonzero.
REQ-013 Subnormal inputs SHALL be treated as zero of the same sign.
REQ-014 A result with the hidden bit still 0 after NORM SHALL flush to zero of the result sign and set underflow.
REQ-015 An exponent reaching all-ones SHALL produce infinity of the result sign and set overflow and inexact.
REQ-016 In ALIGN, special cases SHALL go directly to DONE:
- any NaN input, or infinity plus opposite-sign infinity -> canonical NaN (sign 0, exponent all-ones, mantissa MSB 1, rest 0) with invalid set;
- otherwise any infinity -> that infinity;
- both operands zero -> zero, sign = AND of both effective signs.
REQ-017 An exact zero from cancellation SHALL be +0.
REQ-018 Latency SHALL be measured from the accept edge:
- out_valid rises after 5 edges when NORM takes one cycle;
- each extra NORM left shift adds one cycle;
- special cases: out_valid after 2 edges;
- worst case bounded by 5+MAN_W+1.
REQ-019 In DONE, result and flags SHALL be held stable while out_valid=1 and out_ready=0.
REQ-020 The result SHALL be consumed on an edge with out_valid && out_ready, after which the FSM returns to IDLE; in_ready rises on the following cycle (no same-cycle re-accept).

Reset
REQ-021 Asserting reset SHALL immediately force state IDLE, in_ready=1, out_valid=0, result=0 and flags=0, regardless of the current state.
REQ-022 An operation in flight at reset SHALL be discarded with no partial output.
REQ-023 Reset deassertion SHALL require no synchronisation inside the block; the first accept is possible on the first edge after deassertion.

Verification
REQ-024 With default parameters, 0x42000000 + 0x42000000 (32+32), op=0 -> result 0x42800000, flags 0, out_valid 5 edges after accept.
REQ-025 0x42000000 + 0x40A00000 (32+5) -> result 0x42140000, flags 0.
REQ-026 0x3F800000 - 0x3F400000 (1.0-0.75) -> result 0x3E800000 after two extra NORM cycles (7 edges); 0x3F800000 - 0x3F800000 -> 0x00000000.
REQ-027 0x7F800000 + 0xFF800000 -> result 0x7FC00000, invalid=1, out_valid after 2 edges; 0x7F7FFFFF + 0x7F7FFFFF -> result 0x7F800000, overflow=1, inexact=1.
REQ-028 Hold out_ready=0 for 10 cycles after out_valid -> result stable and in_ready=0 throughout; assert reset during NORM -> out_valid=0 and in_ready=1 immediately.
REQ-029 Random operand sweep across EXP_W/MAN_W = 8/23 and 5/10 -> bit-exact against a reference model using RNE and flush-to-zero.
